// File: rtl/cnn_axis_pkg.sv
// cnn_axis_pkg: shared widths, output FSM states and pixel/keep helpers for the AXIS result path
package cnn_axis_pkg;
  localparam int DEF_AXIS_DATA_WIDTH = 64;
  localparam int DEF_ACCUM_WIDTH = 32;
  localparam int DEF_PIXEL_WIDTH = 16;
  localparam int DEF_IMG_WIDTH = 16;
  localparam int DEF_IMG_HEIGHT = 16;
  localparam int PPB = DEF_AXIS_DATA_WIDTH / DEF_PIXEL_WIDTH;
  localparam int DEF_NPIX = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [63:0] keep_mask(int n, int bytes_per_pix);
    return (64'd1 << (n * bytes_per_pix)) - 64'd1;
  endfunction
  function automatic longint sat_shift(longint value, int shift, int pixel_width);
    longint hi = (longint'(1) <<< (pixel_width - 1)) - 1;
    longint t = value >>> shift;
    return t > hi ? hi : (t < -hi - 1 ? -hi - 1 : t);
  endfunction
endpackage

// File: rtl/res_sat_shift.sv
// res_sat_shift: arithmetic right shift of a signed accumulator, saturated to a signed pixel
module res_sat_shift
  import cnn_axis_pkg::*;
#(
  parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic [ACCUM_WIDTH-1:0] acc,
  input  logic [4:0]             shift,
  output logic [PIXEL_WIDTH-1:0] pixel
);
  assign pixel = PIXEL_WIDTH'(sat_shift(longint'($signed(acc)), int'(shift), PIXEL_WIDTH));
endmodule

// File: rtl/result_axis_packer.sv
// result_axis_packer: packs saturated results into AXIS beats with tkeep/tlast and frame-done pulse
module result_axis_packer
  import cnn_axis_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
  parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_res_valid,
  output logic                         o_res_ready,
  input  logic [ACCUM_WIDTH-1:0]       i_res_data,
  input  logic [4:0]                   i_shift,
  input  logic                         i_clear,
  output logic                         m_axis_res_tvalid,
  input  logic                         m_axis_res_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_res_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_res_tkeep,
  output logic                         m_axis_res_tlast,
  output logic                         o_frame_done
);
  localparam int LANES = AXIS_DATA_WIDTH / PIXEL_WIDTH;
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int LANE_W = cnt_w(LANES);
  localparam int PIX_W = cnt_w(NPIX);
  out_state_t state, state_n;
  logic [LANE_W-1:0] lane;
  logic [PIX_W-1:0] pix_cnt;
  logic [AXIS_DATA_WIDTH-1:0] pack, pack_n;
  logic [PIXEL_WIDTH-1:0] pixel;
  logic [KEEP_W-1:0] keep_n;
  logic accept, frame_last, beat_done;
  res_sat_shift #(.ACCUM_WIDTH(ACCUM_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)) u_sat (
    .acc(i_res_data),
    .shift(i_shift),
    .pixel(pixel)
  );
  assign m_axis_res_tvalid = state == OUT_FULL;
  // Handshake, lane insertion, beat completion and output next state
  always_comb begin
    o_res_ready = !m_axis_res_tvalid | m_axis_res_tready;
    accept = i_res_valid & o_res_ready;
    frame_last = pix_cnt == PIX_W'(NPIX - 1);
    beat_done = accept & (lane == LANE_W'(LANES - 1) | frame_last);
    pack_n = pack | (AXIS_DATA_WIDTH'(pixel) << (int'(lane) * PIXEL_WIDTH));
    keep_n = KEEP_W'(keep_mask(int'(lane) + 1, PIXEL_WIDTH / 8));
    state_n = beat_done ? OUT_FULL : (m_axis_res_tvalid & m_axis_res_tready) ? OUT_EMPTY : state;
  end
  // Counters, pack register and output beat; clear drops everything in flight
  always_ff @(posedge clk) begin
    if (rst | i_clear) begin
      state <= OUT_EMPTY;
      lane <= '0;
      pix_cnt <= '0;
      pack <= '0;
      m_axis_res_tdata <= '0;
      m_axis_res_tkeep <= '0;
      m_axis_res_tlast <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state <= state_n;
      o_frame_done <= m_axis_res_tvalid & m_axis_res_tready & m_axis_res_tlast;
      if (accept) begin
        lane <= beat_done ? '0 : lane + 1'b1;
        pix_cnt <= frame_last ? '0 : pix_cnt + 1'b1;
        pack <= beat_done ? '0 : pack_n;
      end
      if (beat_done) begin
        m_axis_res_tdata <= pack_n;
        m_axis_res_tkeep <= keep_n;
        m_axis_res_tlast <= frame_last;
      end
    end
  end
endmodule

// File: tb/tb_result_axis_packer.sv
// tb_result_axis_packer: stream-level scoreboard for a 16x16 and a 5x5 packer sharing one input stream
module tb_result_axis_packer;
  import cnn_axis_pkg::*;
  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  typedef struct { logic [31:0] data; logic [4:0] sh; logic [15:0] pix; } vec_t;
  logic clk = 0, rst = 1, i_res_valid = 0, i_clear = 0, tready = 1;
  logic [31:0] i_res_data = 0;
  logic [4:0] i_shift = 0;
  logic rdy[2], tv[2], tl[2], fd[2];
  logic [63:0] td[2];
  logic [7:0] tk[2];
  int checks = 0, failures = 0;
  int pq0[$], pq1[$];
  beat_t lg0[$], lg1[$];
  int pos[2] = '{0, 0}, beats[2] = '{0, 0}, lasts[2] = '{0, 0}, dones[2] = '{0, 0}, accepted[2] = '{0, 0};
  logic exp_done[2] = '{0, 0}, hold_v[2] = '{0, 0}, hold_l[2] = '{0, 0};
  logic [63:0] hold_d[2];
  logic [7:0] hold_k[2];
  vec_t tab[8];

  always #5 clk = ~clk;

  result_axis_packer dut (
    .clk(clk), .rst(rst), .i_res_valid(i_res_valid), .o_res_ready(rdy[0]),
    .i_res_data(i_res_data), .i_shift(i_shift), .i_clear(i_clear),
    .m_axis_res_tvalid(tv[0]), .m_axis_res_tready(tready), .m_axis_res_tdata(td[0]),
    .m_axis_res_tkeep(tk[0]), .m_axis_res_tlast(tl[0]), .o_frame_done(fd[0])
  );
  result_axis_packer #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk(clk), .rst(rst), .i_res_valid(i_res_valid), .o_res_ready(rdy[1]),
    .i_res_data(i_res_data), .i_shift(i_shift), .i_clear(i_clear),
    .m_axis_res_tvalid(tv[1]), .m_axis_res_tready(tready), .m_axis_res_tdata(td[1]),
    .m_axis_res_tkeep(tk[1]), .m_axis_res_tlast(tl[1]), .o_frame_done(fd[1])
  );

  function automatic int npix(int d);
    return d != 0 ? 25 : DEF_NPIX;
  endfunction
  function automatic int qsz(int d);
    return d != 0 ? pq1.size() : pq0.size();
  endfunction
  function automatic int qat(int d, int i);
    return d != 0 ? pq1[i] : pq0[i];
  endfunction
  function automatic logic [15:0] ref_pix(logic [31:0] data, logic [4:0] sh);
    longint v = longint'($signed(data)) >>> sh;
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h at %0t", name, d, act, exp, $time);
    end
  endtask
  task automatic qpush(int d, int v);
    if (d != 0) pq1.push_back(v); else pq0.push_back(v);
  endtask
  task automatic qpop(int d, int n);
    repeat (n) if (d != 0) void'(pq1.pop_front()); else void'(pq0.pop_front());
  endtask
  task automatic lgpush(int d, beat_t b);
    if (d != 0) lg1.push_back(b); else lg0.push_back(b);
  endtask
  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      beats[d] = 0; lasts[d] = 0; dones[d] = 0; accepted[d] = 0;
    end
    lg0.delete();
    lg1.delete();
  endtask

  // Expected head beat: up to PPB queued pixels, cut after a frame-final one
  task automatic exp_beat(input int d, output logic [63:0] data, output logic [7:0] keep,
                          output logic last, output logic cmp, output int n);
    int v;
    data = '0; last = 0; n = 0;
    for (int i = 0; i < PPB && i < qsz(d) && !last; i++) begin
      v = qat(d, i);
      data |= 64'(v[15:0]) << (16 * i);
      last = v[16];
      n++;
    end
    cmp = last || n == PPB;
    keep = 8'((64'd1 << (2 * n)) - 64'd1);
  endtask

  task automatic cyc();
    logic clr;
    logic acc[2], hs[2], el[2], ec[2];
    logic [63:0] ed[2];
    logic [7:0] ek[2];
    int en[2];
    beat_t sb[2];
    logic [15:0] pix;
    @(negedge clk);
    clr = rst | i_clear;
    pix = ref_pix(i_res_data, i_shift);
    for (int d = 0; d < 2; d++) begin
      exp_beat(d, ed[d], ek[d], el[d], ec[d], en[d]);
      chk("tvalid", d, 64'(tv[d]), 64'(ec[d]));
      if (ec[d]) begin
        chk("tdata", d, td[d], ed[d]);
        chk("tkeep", d, 64'(tk[d]), 64'(ek[d]));
        chk("tlast", d, 64'(tl[d]), 64'(el[d]));
      end
      chk("ready", d, 64'(rdy[d]), 64'(!tv[d] | tready));
      chk("frame_done", d, 64'(fd[d]), 64'(exp_done[d]));
      if (hold_v[d]) begin
        chk("hold_data", d, td[d], hold_d[d]);
        chk("hold_ctl", d, {54'b0, tv[d], tl[d], tk[d]}, {54'b0, 1'b1, hold_l[d], hold_k[d]});
      end
      hold_v[d] = tv[d] & !tready & !clr;
      hold_d[d] = td[d]; hold_k[d] = tk[d]; hold_l[d] = tl[d];
      acc[d] = i_res_valid & rdy[d] & !clr;
      hs[d] = tv[d] & tready & !clr;
      sb[d].data = td[d]; sb[d].keep = tk[d]; sb[d].last = tl[d];
      if (fd[d]) dones[d]++;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        qpop(d, qsz(d));
        pos[d] = 0;
        exp_done[d] = 0;
      end else begin
        exp_done[d] = hs[d] & el[d];
        if (hs[d]) begin
          qpop(d, en[d]);
          beats[d]++;
          if (sb[d].last) lasts[d]++;
          lgpush(d, sb[d]);
        end
        if (acc[d]) begin
          qpush(d, {15'b0, pos[d] == npix(d) - 1, pix});
          pos[d] = pos[d] == npix(d) - 1 ? 0 : pos[d] + 1;
          accepted[d]++;
        end
      end
    end
  endtask

  task automatic send(int v);
    i_res_valid = 1;
    i_res_data = v;
    cyc();
  endtask
  task automatic drain(int n);
    i_res_valid = 0;
    repeat (n) cyc();
  endtask
  task automatic pulse_clear();
    i_clear = 1;
    cyc();
    i_clear = 0;
  endtask
  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_tvalid", d, 64'(tv[d]), 0);
      chk("rst_tlast", d, 64'(tl[d]), 0);
      chk("rst_done", d, 64'(fd[d]), 0);
      chk("rst_tdata", d, td[d], 0);
      chk("rst_tkeep", d, 64'(tk[d]), 0);
      chk("rst_ready", d, 64'(rdy[d]), 1);
    end
  endtask

  initial begin
    logic [63:0] b;
    int stall, stalled;
    tab[0] = '{32'h0010_0000, 5'd4, 16'h7FFF};
    tab[1] = '{32'hFFF0_0000, 5'd4, 16'h8000};
    tab[2] = '{32'hFFFF_FFEF, 5'd4, 16'hFFFE};
    tab[3] = '{32'h0000_0020, 5'd4, 16'h0002};
    tab[4] = '{32'h7FFF_FFFF, 5'd0, 16'h7FFF};
    tab[5] = '{32'h8000_0000, 5'd31, 16'hFFFF};
    tab[6] = '{32'h0001_2345, 5'd4, 16'h1234};
    tab[7] = '{32'hFFFF_8000, 5'd0, 16'h8000};
    repeat (2) cyc();
    chk_reset();
    rst = 0;

    clear_stats();
    for (int i = 0; i < 256; i++) send(i);
    drain(3);
    chk("ff_beats", 0, beats[0], 64);
    chk("ff_beat0", 0, lg0[0].data, 64'h0003_0002_0001_0000);
    chk("ff_keep40", 0, 64'(lg0[40].keep), 64'hFF);
    chk("ff_last63", 0, 64'(lg0[63].last), 1);
    chk("ff_lasts", 0, lasts[0], 1);
    chk("ff_dones", 0, dones[0], 1);

    pulse_clear();
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      i_res_valid = 1;
      i_res_data = tab[k].data;
      i_shift = tab[k].sh;
      cyc();
    end
    drain(3);
    for (int k = 0; k < 8; k++) begin
      b = lg0[k / 4].data >> (16 * (k % 4));
      chk("sat_vec", k, 64'(b[15:0]), 64'(tab[k].pix));
    end

    pulse_clear();
    clear_stats();
    i_shift = 0;
    for (int i = 0; i < 50; i++) send(100 + i);
    drain(3);
    chk("rag_beats", 1, beats[1], 14);
    chk("rag_keep6", 1, 64'(lg1[6].keep), 64'h03);
    chk("rag_last6", 1, 64'(lg1[6].last), 1);
    chk("rag_upper6", 1, lg1[6].data >> 16, 0);
    chk("rag_data6", 1, lg1[6].data, 64'd124);
    chk("rag_next7", 1, lg1[7].data, 64'h0080_007F_007E_007D);
    chk("rag_last13", 1, 64'(lg1[13].last), 1);
    chk("rag_dones", 1, dones[1], 2);

    pulse_clear();
    clear_stats();
    i_shift = 3;
    stall = 0;
    stalled = 0;
    for (int c = 0; c < 8000 && !(accepted[0] == 256 && qsz(0) == 0); c++) begin
      i_res_valid = accepted[0] < 256 && $urandom_range(3) != 0;
      i_res_data = $urandom_range(1) != 0 ? $urandom : 32'($urandom_range(4000)) - 32'd2000;
      if (stall > 0) begin
        tready = 0;
        stall--;
      end else if (tv[0] && tl[0] && stalled == 0) begin
        stalled = 1;
        stall = 9;
        tready = 0;
      end else tready = 1'($urandom_range(1));
      cyc();
    end
    tready = 1;
    drain(2);
    chk("bp_pixels", 0, accepted[0], 256);
    chk("bp_beats", 0, beats[0], 64);
    chk("bp_lasts", 0, lasts[0], 1);
    chk("bp_dones", 0, dones[0], 1);
    chk("bp_stalled", 0, stalled, 1);

    pulse_clear();
    clear_stats();
    i_shift = 0;
    tready = 0;
    for (int i = 0; i < 6; i++) send(500 + i);
    chk("clr_pending", 0, 64'(tv[0]), 1);
    chk("clr_ready_low", 0, 64'(rdy[0]), 0);
    i_clear = 1;
    cyc();
    i_clear = 0;
    chk("clr_tvalid", 0, 64'(tv[0]), 0);
    chk("clr_tvalid", 1, 64'(tv[1]), 0);
    clear_stats();
    tready = 1;
    for (int i = 0; i < 256; i++) send(2000 + i);
    drain(3);
    chk("clr_first", 0, lg0[0].data, 64'h07D3_07D2_07D1_07D0);
    chk("clr_beats", 0, beats[0], 64);
    chk("clr_last62", 0, 64'(lg0[62].last), 0);
    chk("clr_last63", 0, 64'(lg0[63].last), 1);
    chk("clr_lasts", 0, lasts[0], 1);

    clear_stats();
    for (int i = 0; i < 100; i++) send(i);
    tready = 0;
    i_res_data = 7;
    repeat (5) cyc();
    chk("rstm_pending", 0, 64'(tv[0]), 1);
    rst = 1;
    cyc();
    chk_reset();
    rst = 0;
    tready = 1;
    drain(3);
    chk("rstm_no_done", 0, dones[0], 0);
    chk("rstm_idle", 0, 64'(tv[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
